// File: rtl/main_fsm.sv
// Multicycle processor control FSM: Moore-style decode of the state register into
// datapath write enables, mux selects and ALU control, with an en-driven stall.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       en,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       branch,
    output logic       branchne,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       zeroext,
    output logic [2:0] aluop,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ITYPEWB = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12,
        S_ANDIEX  = 4'd13,
        S_ORIEX   = 4'd14,
        S_UNUSED  = 4'd15
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_BNE:       state_d = S_BNEEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ANDI:      state_d = S_ANDIEX;
                    OP_ORI:       state_d = S_ORIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX,
            S_ANDIEX,
            S_ORIEX:   state_d = S_ITYPEWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite  = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        memwrite = 1'b0;
        branch   = 1'b0;
        branchne = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        zeroext  = 1'b0;
        aluop    = 3'b000;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                // illegal is the one output that looks at op directly
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE,
                    OP_ADDI, OP_ANDI, OP_ORI, OP_J: illegal = 1'b0;
                    default:                        illegal = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 3'b010;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_ITYPEWB: regwrite = 1'b1;
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 3'b001;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_BNEEX: begin
                alusrca  = 1'b1;
                aluop    = 3'b001;
                pcsrc    = 2'b01;
                branchne = 1'b1;
            end
            S_ANDIEX, S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                zeroext = 1'b1;
                aluop   = (state_q == S_ANDIEX) ? 3'b100 : 3'b011;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase

        // A stall suppresses every side effect but keeps the datapath steering stable
        if (!en) begin
            pcwrite  = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            branch   = 1'b0;
            branchne = 1'b0;
            illegal  = 1'b0;
        end

        if (!reset) begin
            pcwrite  = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            branch   = 1'b0;
            branchne = 1'b0;
            iord     = 1'b0;
            memtoreg = 1'b0;
            regdst   = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = 2'b00;
            pcsrc    = 2'b00;
            zeroext  = 1'b0;
            aluop    = 3'b000;
            illegal  = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: directed instruction sequences, stalls and resets, then random
// instruction streams with random en stalls checked against a path/output-table model.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       en;
    logic       pcwrite, irwrite, regwrite, memwrite, branch, branchne;
    logic       iord, memtoreg, regdst, alusrca, zeroext, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluop;
    logic [3:0] state;

    typedef struct packed {
        logic       pcwrite;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       branch;
        logic       branchne;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       zeroext;
        logic [2:0] aluop;
        logic       illegal;
    } outs_t;

    outs_t obs;
    outs_t tbl [16];
    int    path_q[$];
    int    checks = 0;
    int    failures = 0;

    assign obs = {pcwrite, irwrite, regwrite, memwrite, branch, branchne, iord,
                  memtoreg, regdst, alusrca, alusrcb, pcsrc, zeroext, aluop, illegal};

    main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .en(en),
        .pcwrite(pcwrite), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
        .branch(branch), .branchne(branchne), .iord(iord), .memtoreg(memtoreg),
        .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .zeroext(zeroext), .aluop(aluop), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [5:0] o);
        return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                         6'b001000, 6'b001100, 6'b001101, 6'b000010};
    endfunction

    // Visited state list for one instruction, starting at FETCH
    function automatic void make_path(input logic [5:0] o);
        path_q = '{0, 1};
        case (o)
            6'b100011: path_q = {path_q, 2, 3, 4};
            6'b101011: path_q = {path_q, 2, 5};
            6'b000000: path_q = {path_q, 6, 7};
            6'b000100: path_q = {path_q, 8};
            6'b000101: path_q = {path_q, 12};
            6'b001000: path_q = {path_q, 9, 10};
            6'b001100: path_q = {path_q, 13, 10};
            6'b001101: path_q = {path_q, 14, 10};
            6'b000010: path_q = {path_q, 11};
            default: ;
        endcase
    endfunction

    function automatic outs_t expect_outs(input int st, input logic e, input logic [5:0] o);
        outs_t x;
        x = tbl[st];
        x.illegal = (st == 1) && !is_legal(o);
        if (!e) begin
            x.pcwrite = 0; x.irwrite = 0; x.regwrite = 0; x.memwrite = 0;
            x.branch = 0; x.branchne = 0; x.illegal = 0;
        end
        return x;
    endfunction

    task automatic chk(input string tag, input int exp_st, input outs_t exp_o);
        checks++;
        assert (state === exp_st[3:0]) else begin
            failures++;
            $error("FAIL %s state: got %0d expected %0d", tag, state, exp_st);
        end
        checks++;
        assert (obs === exp_o) else begin
            failures++;
            $error("FAIL %s outputs (state %0d): got %h expected %h", tag, exp_st, obs, exp_o);
        end
    endtask

    // Entered at a falling edge; drives, checks, then waits for the next falling edge
    task automatic cycle(input string tag, input logic [5:0] o, input logic e, input int exp_st);
        op = o;
        en = e;
        #1;
        chk(tag, exp_st, expect_outs(exp_st, e, o));
        @(negedge clk);
    endtask

    task automatic run_instr(input string tag, input logic [5:0] o, input int stall_pct);
        int idx;
        int guard;
        logic e;
        make_path(o);
        idx = 0;
        guard = 0;
        while (idx < path_q.size() && guard < 200) begin
            e = ($urandom_range(0, 99) >= stall_pct);
            cycle(tag, o, e, path_q[idx]);
            if (e) idx++;
            guard++;
        end
        checks++;
        assert (guard < 200) else begin
            failures++;
            $error("FAIL %s cycle budget: got %0d expected <200", tag, guard);
        end
    endtask

    initial begin
        outs_t z;
        logic [5:0] rop;
        logic [5:0] legal_ops [9];
        z = '0;
        for (int i = 0; i < 16; i++) tbl[i] = '0;
        tbl[0].irwrite = 1; tbl[0].pcwrite = 1; tbl[0].alusrcb = 2'b01;
        tbl[1].alusrcb = 2'b11;
        tbl[2].alusrca = 1; tbl[2].alusrcb = 2'b10;
        tbl[3].iord = 1;
        tbl[4].memtoreg = 1; tbl[4].regwrite = 1;
        tbl[5].iord = 1; tbl[5].memwrite = 1;
        tbl[6].alusrca = 1; tbl[6].aluop = 3'b010;
        tbl[7].regdst = 1; tbl[7].regwrite = 1;
        tbl[8].alusrca = 1; tbl[8].aluop = 3'b001; tbl[8].pcsrc = 2'b01; tbl[8].branch = 1;
        tbl[9].alusrca = 1; tbl[9].alusrcb = 2'b10;
        tbl[10].regwrite = 1;
        tbl[11].pcsrc = 2'b10; tbl[11].pcwrite = 1;
        tbl[12].alusrca = 1; tbl[12].aluop = 3'b001; tbl[12].pcsrc = 2'b01; tbl[12].branchne = 1;
        tbl[13].alusrca = 1; tbl[13].alusrcb = 2'b10; tbl[13].zeroext = 1; tbl[13].aluop = 3'b100;
        tbl[14].alusrca = 1; tbl[14].alusrcb = 2'b10; tbl[14].zeroext = 1; tbl[14].aluop = 3'b011;
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                      6'b001000, 6'b001100, 6'b001101, 6'b000010};

        reset = 1'b0;
        en = 1'b1;
        op = 6'b100011;
        @(negedge clk);
        #1;
        chk("reset_held", 0, z);
        @(negedge clk);
        reset = 1'b1;

        run_instr("lw", 6'b100011, 0);
        run_instr("sw", 6'b101011, 0);
        run_instr("bne", 6'b000101, 0);
        run_instr("ori", 6'b001101, 0);
        run_instr("illegal", 6'b111111, 0);
        run_instr("beq", 6'b000100, 0);
        run_instr("j", 6'b000010, 0);
        run_instr("andi", 6'b001100, 0);
        run_instr("addi", 6'b001000, 0);

        cycle("fetch_stall", 6'b000000, 1'b0, 0);
        cycle("fetch_retry", 6'b000000, 1'b1, 0);
        cycle("rt_dec", 6'b000000, 1'b1, 1);
        cycle("rt_ex", 6'b000000, 1'b1, 6);
        cycle("rt_wb_stall1", 6'b000000, 1'b0, 7);
        cycle("rt_wb_stall2", 6'b000000, 1'b0, 7);
        cycle("rt_wb_go", 6'b000000, 1'b1, 7);

        cycle("rt2_fetch", 6'b000000, 1'b1, 0);
        cycle("rt2_dec", 6'b000000, 1'b1, 1);
        op = 6'b000000;
        en = 1'b1;
        #1;
        chk("rt2_ex", 6, tbl[6]);
        reset = 1'b0;
        #1;
        chk("async_reset", 0, z);
        @(negedge clk);
        #1;
        chk("reset_across_edge", 0, z);
        @(negedge clk);
        reset = 1'b1;
        run_instr("post_reset_lw", 6'b100011, 0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 9) begin
                rop = 6'($urandom);
                while (is_legal(rop)) rop = 6'($urandom);
            end else begin
                rop = legal_ops[$urandom_range(0, 8)];
            end
            run_instr("rand", rop, 25);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
